// File: rtl/sdiv_seq.sv
// Sequential signed divider: one restoring iteration per clock, start/done handshake.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module sdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg, state_next;
  logic             sign_a_reg, sign_b_reg, dz_reg, ov_reg;
  logic [WIDTH-1:0] a_reg, dvd_reg, q_reg;
  logic [WIDTH:0]   mag_b_reg, rem_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             fits;
  logic             last_iter;

  assign accept    = (state_reg == IDLE) && start;
  // |MIN| = 2^(W-1) is still exact as an unsigned W-bit value.
  assign mag_a     = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign mag_b     = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign rem_shift = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign fits      = (rem_shift >= mag_b_reg);
  assign rem_sub   = rem_shift - mag_b_reg;
  assign last_iter = (cnt_reg == CW'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      dz_reg     <= 1'b0;
      ov_reg     <= 1'b0;
      a_reg      <= '0;
      dvd_reg    <= '0;
      q_reg      <= '0;
      mag_b_reg  <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      done       <= 1'b0;
      Quotient   <= '0;
      Remainder  <= '0;
      div_zero   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sign_a_reg <= A[WIDTH-1];
        sign_b_reg <= B[WIDTH-1];
        dz_reg     <= (B == '0);
        ov_reg     <= (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
        a_reg      <= A;
        dvd_reg    <= mag_a;
        mag_b_reg  <= {1'b0, mag_b};
        rem_reg    <= '0;
        q_reg      <= '0;
        cnt_reg    <= '0;
      end else if (state_reg == RUN && !last_iter) begin
        // The extra RUN cycle at cnt==WIDTH pads latency to WIDTH+2.
        rem_reg <= fits ? rem_sub : rem_shift;
        q_reg   <= {q_reg[WIDTH-2:0], fits};
        dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
        cnt_reg <= cnt_reg + CW'(1);
      end else if (state_reg == FIX) begin
        done     <= 1'b1;
        div_zero <= dz_reg;
        overflow <= ov_reg;
        if (dz_reg) begin
          Quotient  <= '1;
          Remainder <= a_reg;
        end else if (ov_reg) begin
          Quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
          Remainder <= '0;
        end else begin
          Quotient  <= (sign_a_reg ^ sign_b_reg) ? (~q_reg + 1'b1) : q_reg;
          Remainder <= sign_a_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];
        end
      end
    end
  end

endmodule
